// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Far end of the rv32i data-memory request/response interface. Accepts one
// word-aligned read and/or byte-masked write at a time, holds it for a
// programmable latency and then pulses dmem_resp for one cycle. Reads return
// the full stored word. Writes land on the clock edge that ends the response
// cycle.
//
// Parameters
//   DEPTH_LOG2 : log2 of the number of 32-bit words stored
//   LATENCY    : request-to-response latency in cycles (1..16)
//   BASE_ADDR  : byte address of word 0
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   dmem_addr  : byte address (bits [1:0] ignored for storage)
//   dmem_rmask : read byte mask, nonzero = read request
//   dmem_wmask : write byte mask, nonzero = write request
//   dmem_wdata : lane-aligned write data
//   dmem_rdata : read word, nonzero only while dmem_resp is high
//   dmem_resp  : one-cycle response pulse
//   dmem_err   : sticky out-of-range flag, cleared by rst only
//
// Build option
//   DMEM_RSP_RANDLAT_EN : when defined, each request draws its latency from a
//                         16-bit Galois LFSR as 1 + (lfsr[3:0] % LATENCY).
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int          DEPTH_LOG2 = 10,
    parameter int          LATENCY    = 1,
    parameter logic [31:0] BASE_ADDR  = 32'h1ECE_B000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic        dmem_err
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_t;

    state_t                  state_reg, state_next;
    logic [4:0]              cnt_reg, cnt_next;
    logic [DEPTH_LOG2-1:0]   idx_reg;
    logic                    in_range_reg;
    logic [3:0]              wmask_reg;
    logic [31:0]             wdata_reg;
    logic                    err_reg;

    logic [31:0]             mem [DEPTH];

    logic                    req;
    logic                    accept;
    logic [31:0]             byte_off;
    logic [31:0]             word_off;
    logic                    req_in_range;
    logic [4:0]              req_lat;

    assign req      = (dmem_rmask | dmem_wmask) != 4'd0;
    assign accept   = req && ((state_reg == ST_IDLE) || (state_reg == ST_RESP));

    // Addresses below BASE_ADDR wrap to a huge offset and fall out of range.
    assign byte_off     = dmem_addr - BASE_ADDR;
    assign word_off     = byte_off >> 2;
    assign req_in_range = (word_off >> DEPTH_LOG2) == 32'd0;

`ifdef DMEM_RSP_RANDLAT_EN
    logic [15:0] lfsr_reg, lfsr_next;

    // Right-shifting Galois form of taps 16,14,13,11.
    assign lfsr_next = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);
    assign req_lat   = 5'd1 + 5'(32'(lfsr_reg[3:0]) % LATENCY);

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_reg <= 16'hACE1;
        end else if (accept) begin
            lfsr_reg <= lfsr_next;
        end
    end
`else
    assign req_lat = 5'(LATENCY);
`endif

    // Next-state logic. RESP accepts a new request exactly like IDLE so
    // back-to-back traffic sustains one request per latency period.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE, ST_RESP: begin
                if (state_reg == ST_RESP) begin
                    state_next = ST_IDLE;
                end
                if (req) begin
                    cnt_next   = req_lat;
                    state_next = (req_lat == 5'd1) ? ST_RESP : ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Counter enters BUSY at L >= 2 and leaves at 1, so it never wraps.
                cnt_next = cnt_reg - 5'd1;
                if (cnt_next == 5'd1) begin
                    state_next = ST_RESP;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= 5'd0;
            idx_reg      <= '0;
            in_range_reg <= 1'b0;
            wmask_reg    <= 4'd0;
            wdata_reg    <= 32'd0;
            err_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if ((state_reg == ST_RESP) && !in_range_reg) begin
                err_reg <= 1'b1;
            end
            if (accept) begin
                idx_reg      <= word_off[DEPTH_LOG2-1:0];
                in_range_reg <= req_in_range;
                wmask_reg    <= dmem_wmask;
                wdata_reg    <= dmem_wdata;
            end
        end
    end

    // Write lands on the edge ending RESP; a reset on that edge drops it.
    always_ff @(posedge clk) begin
        if (!rst && (state_reg == ST_RESP) && in_range_reg) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask_reg[b]) begin
                    mem[idx_reg][8*b +: 8] <= wdata_reg[8*b +: 8];
                end
            end
        end
    end

    // Combinational read during RESP returns the pre-write word.
    assign dmem_resp  = (state_reg == ST_RESP);
    assign dmem_rdata = (dmem_resp && in_range_reg) ? mem[idx_reg] : 32'd0;
    assign dmem_err   = err_reg;

endmodule
